rt_mu_ctrl: RTL and testbench

- Sequencing controller and initiator for one Nr-wide racetrack LiM memory unit (Nr tracks, Nb domains, Np ports).
- Accepts word-level requests: data read, data write, mask write, LiM read.
- Generates the cycle-by-cycle shift, write, field and read control sequence the array expects, then returns the read word.
- Sits between the core-side LiM memory interface and the array instance.

---
 rtl/rt_mu_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_rt_mu_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_mu_ctrl.sv
// rt_mu_ctrl: sequencing controller for one racetrack LiM memory unit.
// Takes word-level requests (read, write data, write mask, LiM read). It
// shifts the addressed domain under its access port, drives the field,
// write or read pulses, shifts back to the home position, and then returns
// the response word.
// Optional build macro: RT_MU_CTRL_SHIFT_CNT_EN adds shift_cnt_o, a
// saturating count of shift pulse cycles.
module rt_mu_ctrl #(
  parameter int Nr = 4,
  parameter int Nb = 32,
  parameter int Np = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [$clog2(Nb)-1:0] req_addr_i,
  input  logic [Nr-1:0]         req_wdata_i,
  input  logic                  req_nand_norn_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [Nr-1:0]         rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
`ifdef RT_MU_CTRL_SHIFT_CNT_EN
  output logic [31:0]           shift_cnt_o,
`endif
  output logic                  Bz_s_o,
  output logic                  Bz_m_o,
  output logic                  read_current_o,
  output logic                  current_s_data_o,
  output logic                  current_s_mask_o,
  output logic                  current_s_lim_o,
  output logic                  current_m_data_o,
  output logic                  current_m_mask_o,
  output logic                  current_m_lim_o,
  output logic [Nr-1:0]         write_i_data_o,
  output logic [Nr-1:0]         write_i_mask_o,
  output logic                  write_en_data_o,
  output logic                  write_en_mask_o,
  output logic                  IN1_NAND_NORn_o,
  output logic [Nb-1:0]         word_lines_o,
  output logic                  out_select_o,
  input  logic [Nr-1:0]         r_data_i
);

  localparam int          AW   = $clog2(Nb);
  localparam int unsigned Nsp  = Nb / Np;
  localparam int unsigned NbU  = Nb;
  localparam int unsigned LastPort = Np - 1;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_MASK = 2'b10;
  localparam logic [1:0] OP_LIM  = 2'b11;

  typedef enum logic [2:0] {IDLE, SHIFT_F, FIELD, ACCESS, SHIFT_B, RESP} state_t;

  state_t          state, state_n;
  logic            phase, phase_n;
  logic [AW-1:0]   steps, steps_n;
  logic [AW-1:0]   addr_q, k_q;
  logic [1:0]      op_q;
  logic [Nr-1:0]   wdata_q;
  logic            sel_q;

  int unsigned     port_idx;
  logic [AW-1:0]   dec_k;
  logic            dec_err;

  logic [AW-1:0]   src_addr;
  logic [1:0]      src_op;
  logic [Nr-1:0]   src_wdata;
  logic            src_sel;
  logic            op_reads;

  // Map an incoming address to its port and shift distance; the last port absorbs the remainder
  always_comb begin
    port_idx = 32'(req_addr_i) / Nsp;
    if (port_idx > LastPort) port_idx = LastPort;
    dec_k   = AW'(32'(req_addr_i) - port_idx * Nsp);
    dec_err = (32'(req_addr_i) >= NbU);
  end

  // Request fields come straight from the inputs in the accept cycle, from the latches afterwards
  always_comb begin
    src_addr  = (state == IDLE) ? req_addr_i      : addr_q;
    src_op    = (state == IDLE) ? req_op_i        : op_q;
    src_wdata = (state == IDLE) ? req_wdata_i     : wdata_q;
    src_sel   = (state == IDLE) ? req_nand_norn_i : sel_q;
    op_reads  = (op_q == OP_RD) || (op_q == OP_LIM);
  end

  // Sequencer: each shift step is a pulse cycle (phase 0) then a gap cycle (phase 1)
  always_comb begin
    state_n = state;
    phase_n = phase;
    steps_n = steps;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          phase_n = 1'b0;
          if (dec_err) begin
            state_n = RESP;
          end else if (dec_k != '0) begin
            state_n = SHIFT_F;
            steps_n = dec_k;
          end else if (req_op_i == OP_LIM) begin
            state_n = FIELD;
          end else begin
            state_n = ACCESS;
          end
        end
      end
      SHIFT_F: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else if (steps > AW'(1)) begin
          steps_n = steps - AW'(1);
          phase_n = 1'b0;
        end else begin
          phase_n = 1'b0;
          state_n = (op_q == OP_LIM) ? FIELD : ACCESS;
        end
      end
      FIELD: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        phase_n = 1'b0;
        if (k_q != '0) begin
          state_n = SHIFT_B;
          steps_n = k_q;
        end else begin
          state_n = RESP;
        end
      end
      SHIFT_B: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else if (steps > AW'(1)) begin
          steps_n = steps - AW'(1);
          phase_n = 1'b0;
        end else begin
          phase_n = 1'b0;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, request latches and every output, registered from the state being entered
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state            <= IDLE;
      phase            <= 1'b0;
      steps            <= '0;
      addr_q           <= '0;
      k_q              <= '0;
      op_q             <= '0;
      wdata_q          <= '0;
      sel_q            <= 1'b0;
      req_ready_o      <= 1'b1;
      busy_o           <= 1'b0;
      rsp_valid_o      <= 1'b0;
      rsp_rdata_o      <= '0;
      rsp_err_o        <= 1'b0;
      Bz_s_o           <= 1'b0;
      Bz_m_o           <= 1'b0;
      read_current_o   <= 1'b0;
      current_s_data_o <= 1'b0;
      current_s_mask_o <= 1'b0;
      current_s_lim_o  <= 1'b0;
      current_m_data_o <= 1'b0;
      current_m_mask_o <= 1'b0;
      current_m_lim_o  <= 1'b0;
      write_i_data_o   <= '0;
      write_i_mask_o   <= '0;
      write_en_data_o  <= 1'b0;
      write_en_mask_o  <= 1'b0;
      IN1_NAND_NORn_o  <= 1'b0;
      word_lines_o     <= '0;
      out_select_o     <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      steps <= steps_n;
      if (state == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        k_q     <= dec_k;
        op_q    <= req_op_i;
        wdata_q <= req_wdata_i;
        sel_q   <= req_nand_norn_i;
      end
      req_ready_o      <= (state_n == IDLE);
      busy_o           <= (state_n != IDLE);
      rsp_valid_o      <= (state_n == RESP);
      current_s_data_o <= (state_n == SHIFT_F) && !phase_n;
      current_s_mask_o <= (state_n == SHIFT_F) && !phase_n;
      current_s_lim_o  <= (state_n == SHIFT_F) && !phase_n;
      current_m_data_o <= (state_n == SHIFT_B) && !phase_n;
      current_m_mask_o <= (state_n == SHIFT_B) && !phase_n;
      current_m_lim_o  <= (state_n == SHIFT_B) && !phase_n;
      Bz_s_o           <= (state_n == FIELD) && !phase_n;
      Bz_m_o           <= (state_n == FIELD) && phase_n;
      IN1_NAND_NORn_o  <= ((state_n == FIELD) || (state_n == ACCESS && src_op == OP_LIM)) ? src_sel : 1'b0;
      word_lines_o     <= (state_n == ACCESS) ? (Nb'(1) << src_addr) : '0;
      read_current_o   <= (state_n == ACCESS) && (src_op == OP_RD || src_op == OP_LIM);
      out_select_o     <= (state_n == ACCESS) && (src_op == OP_LIM);
      write_en_data_o  <= (state_n == ACCESS) && (src_op == OP_WR);
      write_en_mask_o  <= (state_n == ACCESS) && (src_op == OP_MASK);
      write_i_data_o   <= (state_n == ACCESS && src_op == OP_WR)   ? src_wdata : '0;
      write_i_mask_o   <= (state_n == ACCESS && src_op == OP_MASK) ? src_wdata : '0;
      if (state == IDLE) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= req_valid_i && dec_err;
      end else if (state == ACCESS && op_reads) begin
        rsp_rdata_o <= r_data_i;
      end else if (state == RESP && rsp_ready_i) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b0;
      end
    end
  end

`ifdef RT_MU_CTRL_SHIFT_CNT_EN
  // Saturating count of forward and backward shift pulse cycles
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      shift_cnt_o <= '0;
    end else if ((current_s_data_o || current_m_data_o) && shift_cnt_o != 32'hFFFF_FFFF) begin
      shift_cnt_o <= shift_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rt_mu_ctrl.sv
// tb_rt_mu_ctrl: randomized self-checking bench for rt_mu_ctrl.
// The reference model builds, for every request, the cycle-by-cycle control
// trace that the array protocol describes. Each cycle of the DUT is then
// compared against that trace.
module tb_rt_mu_ctrl;

  localparam int Nr  = 4;
  localparam int Nb  = 32;
  localparam int Np  = 8;
  localparam int Nsp = Nb / Np;
  localparam int AW  = $clog2(Nb);

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [1:0]      req_op_i = '0;
  logic [AW-1:0]   req_addr_i = '0;
  logic [Nr-1:0]   req_wdata_i = '0;
  logic            req_nand_norn_i = 1'b0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [Nr-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic            busy_o;
  logic            Bz_s_o, Bz_m_o, read_current_o;
  logic            current_s_data_o, current_s_mask_o, current_s_lim_o;
  logic            current_m_data_o, current_m_mask_o, current_m_lim_o;
  logic [Nr-1:0]   write_i_data_o, write_i_mask_o;
  logic            write_en_data_o, write_en_mask_o;
  logic            IN1_NAND_NORn_o;
  logic [Nb-1:0]   word_lines_o;
  logic            out_select_o;
  logic [Nr-1:0]   r_data_i;
  logic [Nr-1:0]   arr_word = '0;
`ifdef RT_MU_CTRL_SHIFT_CNT_EN
  logic [31:0]     shift_cnt_o;
`endif

  typedef struct packed {
    logic          ready;
    logic          busy;
    logic          rvalid;
    logic          bzs;
    logic          bzm;
    logic          rdc;
    logic [2:0]    fwd;
    logic [2:0]    bwd;
    logic          wend;
    logic          wenm;
    logic [Nr-1:0] wid;
    logic [Nr-1:0] wim;
    logic          in1;
    logic          osel;
    logic [Nb-1:0] wl;
  } ctrl_t;

  ctrl_t exp_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;
  int    exp_shift_total = 0;

  rt_mu_ctrl #(.Nr(Nr), .Nb(Nb), .Np(Np)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_nand_norn_i(req_nand_norn_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o),
`ifdef RT_MU_CTRL_SHIFT_CNT_EN
    .shift_cnt_o(shift_cnt_o),
`endif
    .Bz_s_o(Bz_s_o), .Bz_m_o(Bz_m_o), .read_current_o(read_current_o),
    .current_s_data_o(current_s_data_o), .current_s_mask_o(current_s_mask_o),
    .current_s_lim_o(current_s_lim_o), .current_m_data_o(current_m_data_o),
    .current_m_mask_o(current_m_mask_o), .current_m_lim_o(current_m_lim_o),
    .write_i_data_o(write_i_data_o), .write_i_mask_o(write_i_mask_o),
    .write_en_data_o(write_en_data_o), .write_en_mask_o(write_en_mask_o),
    .IN1_NAND_NORn_o(IN1_NAND_NORn_o), .word_lines_o(word_lines_o),
    .out_select_o(out_select_o), .r_data_i(r_data_i)
  );

  always #5 clk_i = ~clk_i;

  // The array only presents the stored word while the read current flows
  assign r_data_i = read_current_o ? arr_word : ~arr_word;

  function automatic ctrl_t observe();
    ctrl_t c;
    c.ready  = req_ready_o;
    c.busy   = busy_o;
    c.rvalid = rsp_valid_o;
    c.bzs    = Bz_s_o;
    c.bzm    = Bz_m_o;
    c.rdc    = read_current_o;
    c.fwd    = {current_s_data_o, current_s_mask_o, current_s_lim_o};
    c.bwd    = {current_m_data_o, current_m_mask_o, current_m_lim_o};
    c.wend   = write_en_data_o;
    c.wenm   = write_en_mask_o;
    c.wid    = write_i_data_o;
    c.wim    = write_i_mask_o;
    c.in1    = IN1_NAND_NORn_o;
    c.osel   = out_select_o;
    c.wl     = word_lines_o;
    return c;
  endfunction

  function automatic int ref_k(input int addr);
    int port;
    port = addr / Nsp;
    if (port > Np - 1) port = Np - 1;
    return addr - port * Nsp;
  endfunction

  function automatic ctrl_t busy_cycle();
    ctrl_t c;
    c = '0;
    c.busy = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t idle_cycle();
    ctrl_t c;
    c = '0;
    c.ready = 1'b1;
    return c;
  endfunction

  task automatic build_trace(input logic [1:0] op, input int addr, input logic [Nr-1:0] wdata, input logic sel);
    ctrl_t c;
    int k;
    k = ref_k(addr);
    exp_q.delete();
    for (int i = 0; i < k; i++) begin
      c = busy_cycle(); c.fwd = 3'b111; exp_q.push_back(c);
      exp_q.push_back(busy_cycle());
    end
    if (op == 2'b11) begin
      c = busy_cycle(); c.bzs = 1'b1; c.in1 = sel; exp_q.push_back(c);
      c = busy_cycle(); c.bzm = 1'b1; c.in1 = sel; exp_q.push_back(c);
    end
    c = busy_cycle();
    c.wl   = Nb'(1) << addr;
    c.rdc  = (op == 2'b00) || (op == 2'b11);
    c.osel = (op == 2'b11);
    c.in1  = (op == 2'b11) ? sel : 1'b0;
    c.wend = (op == 2'b01);
    c.wid  = (op == 2'b01) ? wdata : '0;
    c.wenm = (op == 2'b10);
    c.wim  = (op == 2'b10) ? wdata : '0;
    exp_q.push_back(c);
    for (int i = 0; i < k; i++) begin
      c = busy_cycle(); c.bwd = 3'b111; exp_q.push_back(c);
      exp_q.push_back(busy_cycle());
    end
    c = busy_cycle(); c.rvalid = 1'b1; exp_q.push_back(c);
    exp_shift_total += 2 * k;
  endtask

  task automatic run_req(input string name, input logic [1:0] op, input int addr, input logic [Nr-1:0] wdata,
                         input logic sel, input logic [Nr-1:0] arr, input int delay);
    ctrl_t obs;
    logic [Nr-1:0] exp_rd;
    int last;
    tests_run++;
    if (req_ready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s accept_ready: got %b expected 1", name, req_ready_o);
    end
    build_trace(op, addr, wdata, sel);
    last = exp_q.size() - 1;
    exp_rd = ((op == 2'b00) || (op == 2'b11)) ? arr : '0;
    arr_word = arr;
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = AW'(addr);
    req_wdata_i = wdata; req_nand_norn_i = sel;
    @(posedge clk_i); #1;
    for (int j = 0; j <= last; j++) begin
      req_valid_i = 1'($urandom); req_op_i = 2'($urandom); req_addr_i = AW'($urandom);
      req_wdata_i = Nr'($urandom); req_nand_norn_i = 1'($urandom);
      if (j == last) begin
        for (int d = 0; d <= delay; d++) begin
          obs = observe();
          tests_run++;
          if (obs !== exp_q[j]) begin
            tests_failed++;
            $display("[TB] FAIL %s resp_ctrl wait %0d: got %h expected %h", name, d, obs, exp_q[j]);
          end
          tests_run++;
          if (rsp_rdata_o !== exp_rd || rsp_err_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s resp_data wait %0d: got %h/%b expected %h/0", name, d, rsp_rdata_o, rsp_err_o, exp_rd);
          end
          rsp_ready_i = (d == delay);
          if (d == delay) req_valid_i = 1'b0;
          @(posedge clk_i); #1;
        end
        rsp_ready_i = 1'b0;
      end else begin
        obs = observe();
        tests_run++;
        if (obs !== exp_q[j]) begin
          tests_failed++;
          $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, j + 1, obs, exp_q[j]);
        end
        @(posedge clk_i); #1;
      end
    end
    obs = observe();
    tests_run++;
    if (obs !== idle_cycle()) begin
      tests_failed++;
      $display("[TB] FAIL %s idle_after: got %h expected %h", name, obs, idle_cycle());
    end
`ifdef RT_MU_CTRL_SHIFT_CNT_EN
    tests_run++;
    if (shift_cnt_o !== 32'(exp_shift_total)) begin
      tests_failed++;
      $display("[TB] FAIL %s shift_cnt: got %0d expected %0d", name, shift_cnt_o, exp_shift_total);
    end
`endif
  endtask

  task automatic check_reset_state(input string name);
    ctrl_t obs;
    obs = observe();
    tests_run++;
    if (obs !== idle_cycle() || rsp_rdata_o !== '0 || rsp_err_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h/%h/%b expected %h/0/0", name, obs, rsp_rdata_o, rsp_err_o, idle_cycle());
    end
`ifdef RT_MU_CTRL_SHIFT_CNT_EN
    tests_run++;
    if (shift_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL %s shift_cnt: got %0d expected 0", name, shift_cnt_o);
    end
`endif
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    check_reset_state("reset");
    rstn_i = 1'b1;
    exp_shift_total = 0;
    @(posedge clk_i); #1;
    check_reset_state("reset_release");
  endtask

  task automatic test_directed();
    run_req("write_addr0", 2'b01, 0, 4'hA, 1'b0, 4'h3, 0);
    run_req("read_addr7", 2'b00, 7, 4'h0, 1'b0, 4'h5, 0);
    run_req("lim_addr31", 2'b11, 31, 4'h0, 1'b1, 4'h9, 0);
    run_req("mask_addr28", 2'b10, 28, 4'h6, 1'b0, 4'h0, 0);
    run_req("lim_nor_addr4", 2'b11, 4, 4'h0, 1'b0, 4'hC, 0);
  endtask

  task automatic test_backpressure();
    run_req("bp_read", 2'b00, 13, 4'h0, 1'b0, 4'hE, 5);
    run_req("bp_follow", 2'b01, 2, 4'h7, 1'b0, 4'h1, 0);
  endtask

  task automatic test_mid_reset();
    ctrl_t obs;
    build_trace(2'b00, 6, 4'h0, 1'b0);
    arr_word = 4'h2;
    req_valid_i = 1'b1; req_op_i = 2'b00; req_addr_i = AW'(6);
    req_wdata_i = '0; req_nand_norn_i = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      obs = observe();
      tests_run++;
      if (obs !== exp_q[j]) begin
        tests_failed++;
        $display("[TB] FAIL mid_reset cycle %0d: got %h expected %h", j + 1, obs, exp_q[j]);
      end
      if (j < 2) begin
        @(posedge clk_i); #1;
      end
    end
    rstn_i = 1'b0;
    @(posedge clk_i); #1;
    check_reset_state("mid_reset");
    rstn_i = 1'b1;
    exp_shift_total = 0;
    @(posedge clk_i); #1;
    check_reset_state("mid_reset_release");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      run_req("random", 2'($urandom), int'($urandom_range(0, Nb - 1)), Nr'($urandom),
              1'($urandom), Nr'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
